// File: rtl/uart_cal_ctrl.sv
// UART calculator frame sequencer: receives A, opcode, B; computes a 16-bit result;
// returns it as two bytes, MSB first, with the receiver disabled during transmit.
module uart_cal_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 2048,
  parameter int unsigned CNT_W       = 12
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_start,
  output logic [7:0]  tx_data,
  output logic        uout_valid,
  input  logic        tx_valid,
  output logic [15:0] result,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {RX_A, RX_OP, RX_B, CALC, TX_HI, TX_GAP, TX_LO} state_t;

  localparam logic [7:0]       OP_ADD  = 8'h2B;
  localparam logic [7:0]       OP_SUB  = 8'h2D;
  localparam logic [7:0]       OP_MUL  = 8'h2A;
  localparam logic [7:0]       OP_DIV  = 8'h2F;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_a, r_op, r_b, r_rem, r_quo;
  logic [2:0]       r_div_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_result;
  logic             r_err;

  logic [8:0]  w_shift;
  logic [7:0]  w_sub, w_rem_nxt, w_quo_nxt;
  logic        w_ge, w_is_div, w_calc_done, w_calc_err, w_timeout;
  logic [15:0] w_calc_res;

  // Restoring divider step: remainder stays below B, so the 8-bit difference is exact.
  assign w_shift     = {r_rem, r_quo[7]};
  assign w_ge        = (w_shift >= {1'b0, r_b});
  assign w_sub       = w_shift[7:0] - r_b;
  assign w_rem_nxt   = w_ge ? w_sub : w_shift[7:0];
  assign w_quo_nxt   = {r_quo[6:0], w_ge};
  assign w_is_div    = (r_op == OP_DIV) && (r_b != 8'h00);
  assign w_calc_done = !w_is_div || (r_div_cnt == 3'd7);
  assign w_timeout   = !rx_valid && (r_cnt == TO_LAST);

  assign result = r_result;
  assign err    = r_err;

  always_comb begin
    w_calc_res = 16'hFFFF;
    w_calc_err = 1'b0;
    case (r_op)
      OP_ADD:  w_calc_res = {8'h00, r_a} + {8'h00, r_b};
      OP_SUB:  w_calc_res = {8'h00, r_a} - {8'h00, r_b};
      OP_MUL:  w_calc_res = {8'h00, r_a} * {8'h00, r_b};
      OP_DIV: begin
        if (r_b != 8'h00) w_calc_res = {8'h00, w_quo_nxt};
        else              w_calc_err = 1'b1;
      end
      default: w_calc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= RX_A;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    rx_start    = 1'b0;
    uout_valid  = 1'b0;
    tx_data     = '0;
    busy        = 1'b0;
    case (r_state)
      RX_A: begin
        rx_start = 1'b1;
        if (rx_valid) w_state_nxt = RX_OP;
      end
      RX_OP: begin
        rx_start = 1'b1;
        if (rx_valid)       w_state_nxt = RX_B;
        else if (w_timeout) w_state_nxt = RX_A;
      end
      RX_B: begin
        rx_start = 1'b1;
        if (rx_valid)       w_state_nxt = CALC;
        else if (w_timeout) w_state_nxt = RX_A;
      end
      CALC: begin
        busy = 1'b1;
        if (w_calc_done) w_state_nxt = TX_HI;
      end
      TX_HI: begin
        busy       = 1'b1;
        uout_valid = 1'b1;
        tx_data    = r_result[15:8];
        if (tx_valid) w_state_nxt = TX_GAP;
      end
      TX_GAP: begin
        busy        = 1'b1;
        w_state_nxt = TX_LO;
      end
      TX_LO: begin
        busy       = 1'b1;
        uout_valid = 1'b1;
        tx_data    = r_result[7:0];
        if (tx_valid) w_state_nxt = RX_A;
      end
      default: w_state_nxt = RX_A;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_a       <= '0;
      r_op      <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div_cnt <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        RX_A: begin
          r_cnt <= '0;
          if (rx_valid) begin
            r_a   <= rx_data;
            r_err <= 1'b0;
          end
        end
        RX_OP, RX_B: begin
          if (rx_valid) begin
            r_cnt <= '0;
            if (r_state == RX_OP) begin
              r_op <= rx_data;
            end else begin
              r_b       <= rx_data;
              r_rem     <= '0;
              r_quo     <= r_a;
              r_div_cnt <= '0;
            end
          end else if (w_timeout) begin
            r_cnt <= '0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CALC: begin
          if (w_is_div) begin
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_div_cnt <= r_div_cnt + 3'd1;
          end
          if (w_calc_done) begin
            r_result <= w_calc_res;
            if (w_calc_err) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
